// File: rtl/pong_match_sequencer.sv
// Match-level sequencer for the pong datapath: menu, serve, play, point pause and game over.
// Optional PONG_ATTRACT_EN: OVER returns to STARTUP by itself after ATTRACT_FRAMES frames.
module pong_match_sequencer #(
   parameter int unsigned WIN_SCORE      = 7,
   parameter int unsigned SERVE_FRAMES   = 60,
   parameter int unsigned PAUSE_FRAMES   = 90,
   parameter int unsigned BLINK_FRAMES   = 8,
   parameter int unsigned ATTRACT_FRAMES = 240
) (
   input  logic       clk_0,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic       game_startup,
   output logic       game_over,
   output logic       sq_shown,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic       serve_req,
   output logic       serve_dir
);

   localparam logic [2:0] ST_STARTUP = 3'd0;
   localparam logic [2:0] ST_SERVE   = 3'd1;
   localparam logic [2:0] ST_PLAY    = 3'd2;
   localparam logic [2:0] ST_PAUSE   = 3'd3;
   localparam logic [2:0] ST_OVER    = 3'd4;

   localparam logic [3:0] WIN_N     = 4'(WIN_SCORE);
   localparam logic [7:0] SERVE_N   = 8'(SERVE_FRAMES);
   localparam logic [7:0] PAUSE_N   = 8'(PAUSE_FRAMES);
   localparam logic [7:0] BLINK_N   = 8'(BLINK_FRAMES);
   localparam logic [7:0] ATTRACT_N = 8'(ATTRACT_FRAMES);

   logic       btn_meta_q, btn_sync_q, btn_prev_q;
   logic       press;
   logic [2:0] state_q, state_d;
   logic [7:0] frame_cnt_q, frame_cnt_d, frame_cnt_inc;
   logic [7:0] blink_cnt_q, blink_cnt_d, blink_cnt_inc;
   logic       blink_q, blink_d;
   logic       startup_q, startup_d;
   logic       over_q, over_d;
   logic       sq_q, sq_d;
   logic [3:0] p1_q, p1_d;
   logic [3:0] p2_q, p2_d;
   logic       serve_req_q, serve_req_d;
   logic       serve_dir_q, serve_dir_d;
   logic       attract_hit;

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      sat_inc = (s >= WIN_N) ? WIN_N : s + 4'd1;
   endfunction

   // Synchronizer and edge register reset high: a button held through reset must be released first.
   assign press = btn_sync_q & ~btn_prev_q;

   assign frame_cnt_inc = frame_cnt_q + 8'd1;
   assign blink_cnt_inc = blink_cnt_q + 8'd1;

`ifdef PONG_ATTRACT_EN
   assign attract_hit = frame_tick & (frame_cnt_inc == ATTRACT_N);
`else
   // Auto-return disabled; the term keeps the parameter referenced.
   assign attract_hit = 1'b0 & (frame_cnt_inc == ATTRACT_N);
`endif

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      startup_d   = startup_q;
      over_d      = over_q;
      sq_d        = sq_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      serve_req_d = 1'b0;
      serve_dir_d = serve_dir_q;

      if (frame_tick) begin
         frame_cnt_d = frame_cnt_inc;
      end

      case (state_q)
         ST_STARTUP: begin
            if (press) begin
               state_d     = ST_SERVE;
               p1_d        = '0;
               p2_d        = '0;
               serve_dir_d = 1'b0;
            end
         end
         ST_SERVE: begin
            if (frame_tick) begin
               if (frame_cnt_inc == SERVE_N) begin
                  state_d = ST_PLAY;
               end
               if (blink_cnt_inc == BLINK_N) begin
                  blink_cnt_d = '0;
                  blink_d     = ~blink_q;
                  sq_d        = ~blink_q;
               end else begin
                  blink_cnt_d = blink_cnt_inc;
               end
            end
         end
         ST_PLAY: begin
            if (miss_left && miss_right) begin
               state_d = ST_PAUSE;
            end else if (miss_left) begin
               p2_d        = sat_inc(p2_q);
               serve_dir_d = 1'b1;
               state_d     = (p2_d == WIN_N) ? ST_OVER : ST_PAUSE;
            end else if (miss_right) begin
               p1_d        = sat_inc(p1_q);
               serve_dir_d = 1'b0;
               state_d     = (p1_d == WIN_N) ? ST_OVER : ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (frame_tick && (frame_cnt_inc == PAUSE_N)) begin
               state_d = ST_SERVE;
            end
         end
         ST_OVER: begin
            if (press || attract_hit) begin
               state_d = ST_STARTUP;
            end
         end
         default: begin
            state_d = ST_STARTUP;
         end
      endcase

      // Entry actions shared by every transition; they override the per-state updates above.
      if (state_d != state_q) begin
         frame_cnt_d = '0;
         startup_d   = (state_d == ST_STARTUP);
         over_d      = (state_d == ST_OVER);
         sq_d        = (state_d == ST_SERVE) || (state_d == ST_PLAY);
         serve_req_d = (state_d == ST_PLAY);
         if (state_d == ST_SERVE) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_0) begin
      if (!rst) begin
         btn_meta_q  <= 1'b1;
         btn_sync_q  <= 1'b1;
         btn_prev_q  <= 1'b1;
         state_q     <= ST_STARTUP;
         frame_cnt_q <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b1;
         startup_q   <= 1'b1;
         over_q      <= 1'b0;
         sq_q        <= 1'b0;
         p1_q        <= '0;
         p2_q        <= '0;
         serve_req_q <= 1'b0;
         serve_dir_q <= 1'b0;
      end else begin
         btn_meta_q  <= start_btn;
         btn_sync_q  <= btn_meta_q;
         btn_prev_q  <= btn_sync_q;
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         startup_q   <= startup_d;
         over_q      <= over_d;
         sq_q        <= sq_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         serve_req_q <= serve_req_d;
         serve_dir_q <= serve_dir_d;
      end
   end

   assign game_startup = startup_q;
   assign game_over    = over_q;
   assign sq_shown     = sq_q;
   assign score_p1     = p1_q;
   assign score_p2     = p2_q;
   assign serve_req    = serve_req_q;
   assign serve_dir    = serve_dir_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Bench for pong_match_sequencer: directed match flow plus random stimulus, checked every cycle
// against a frame-counting behavioural model of the match rules.
module tb_pong_match_sequencer;

   localparam int WIN     = 3;
   localparam int SERVE   = 4;
   localparam int PAUSE   = 3;
   localparam int BLINK   = 2;
   localparam int ATTRACT = 5;

   localparam int M_START = 0;
   localparam int M_SERVE = 1;
   localparam int M_PLAY  = 2;
   localparam int M_PAUSE = 3;
   localparam int M_OVER  = 4;

   logic       clk_0 = 1'b0;
   logic       rst = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       miss_left = 1'b0;
   logic       miss_right = 1'b0;
   logic       game_startup, game_over, sq_shown, serve_req, serve_dir;
   logic [3:0] score_p1, score_p2;

   int errors = 0;
   int checks = 0;

   always #5 clk_0 = ~clk_0;

   pong_match_sequencer #(
      .WIN_SCORE(WIN),
      .SERVE_FRAMES(SERVE),
      .PAUSE_FRAMES(PAUSE),
      .BLINK_FRAMES(BLINK),
      .ATTRACT_FRAMES(ATTRACT)
   ) dut (
      .clk_0(clk_0),
      .rst(rst),
      .frame_tick(frame_tick),
      .start_btn(start_btn),
      .miss_left(miss_left),
      .miss_right(miss_right),
      .game_startup(game_startup),
      .game_over(game_over),
      .sq_shown(sq_shown),
      .score_p1(score_p1),
      .score_p2(score_p2),
      .serve_req(serve_req),
      .serve_dir(serve_dir)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode, frames counted since entering it, scores, button history.
   int       m_mode = M_START;
   int       m_ticks = 0;
   int       m_p1 = 0;
   int       m_p2 = 0;
   bit       m_dir = 1'b0;
   bit       m_serve = 1'b0;
   bit       m_valid = 1'b0;
   bit [2:0] hist = 3'b111;

   always @(posedge clk_0) begin : model
      bit press;
      if (!rst) begin
         m_mode = M_START; m_ticks = 0; m_p1 = 0; m_p2 = 0;
         m_dir = 1'b0; m_serve = 1'b0; hist = 3'b111; m_valid = 1'b1;
      end else begin
         press = hist[1] && !hist[2];
         m_serve = 1'b0;
         case (m_mode)
            M_START: if (press) begin
               m_mode = M_SERVE; m_ticks = 0; m_p1 = 0; m_p2 = 0; m_dir = 1'b0;
            end
            M_SERVE: if (frame_tick) begin
               m_ticks++;
               if (m_ticks == SERVE) begin m_mode = M_PLAY; m_ticks = 0; m_serve = 1'b1; end
            end
            M_PLAY: begin
               if (miss_left && miss_right) begin
                  m_mode = M_PAUSE; m_ticks = 0;
               end else if (miss_left) begin
                  m_p2 = (m_p2 + 1 > WIN) ? WIN : m_p2 + 1;
                  m_dir = 1'b1; m_ticks = 0;
                  m_mode = (m_p2 == WIN) ? M_OVER : M_PAUSE;
               end else if (miss_right) begin
                  m_p1 = (m_p1 + 1 > WIN) ? WIN : m_p1 + 1;
                  m_dir = 1'b0; m_ticks = 0;
                  m_mode = (m_p1 == WIN) ? M_OVER : M_PAUSE;
               end
            end
            M_PAUSE: if (frame_tick) begin
               m_ticks++;
               if (m_ticks == PAUSE) begin m_mode = M_SERVE; m_ticks = 0; end
            end
            default: begin
               if (press) begin
                  m_mode = M_START; m_ticks = 0;
               end else if (frame_tick) begin
                  m_ticks++;
`ifdef PONG_ATTRACT_EN
                  if (m_ticks == ATTRACT) begin m_mode = M_START; m_ticks = 0; end
`endif
               end
            end
         endcase
         hist = {hist[1:0], start_btn};
      end
   end

   always @(negedge clk_0) begin : compare
      bit exp_sq;
      if (m_valid) begin
         if (m_mode == M_PLAY) exp_sq = 1'b1;
         else if (m_mode == M_SERVE) exp_sq = ((m_ticks / BLINK) % 2) == 0;
         else exp_sq = 1'b0;
         check("game_startup", 32'(game_startup), 32'(m_mode == M_START));
         check("game_over", 32'(game_over), 32'(m_mode == M_OVER));
         check("sq_shown", 32'(sq_shown), 32'(exp_sq));
         check("score_p1", 32'(score_p1), 32'(m_p1));
         check("score_p2", 32'(score_p2), 32'(m_p2));
         check("serve_req", 32'(serve_req), 32'(m_serve));
         check("serve_dir", 32'(serve_dir), 32'(m_dir));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_0);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         frame_tick = 1'b1;
         @(negedge clk_0);
         frame_tick = 1'b0;
      end
   endtask

   task automatic pulse_miss(input bit l, input bit r);
      miss_left = l;
      miss_right = r;
      @(negedge clk_0);
      miss_left = 1'b0;
      miss_right = 1'b0;
   endtask

   initial begin
      bit pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

      @(negedge clk_0);
      rst = 1'b0; start_btn = 1'b1;
      cyc(3);
      rst = 1'b1;
      cyc(1);
      check("lit_reset_startup", 32'(game_startup), 32'd1);
      check("lit_reset_sq", 32'(sq_shown), 32'd0);
      cyc(6);
      check("lit_held_btn_no_press", 32'(game_startup), 32'd1);
      start_btn = 1'b0;
      cyc(4);
      check("lit_released_startup", 32'(game_startup), 32'd1);
      start_btn = 1'b1;
      cyc(2);
      check("lit_press_2nd_edge", 32'(game_startup), 32'd1);
      cyc(1);
      check("lit_press_3rd_edge", 32'(game_startup), 32'd0);
      check("lit_scores_cleared", 32'({score_p1, score_p2}), 32'd0);
      start_btn = 1'b0;

      check("lit_serve_entry_sq", 32'(sq_shown), 32'd1);
      for (int i = 0; i < 4; i++) begin
         ticks(1);
         check("lit_blink_pattern", 32'(sq_shown), 32'(pat[i]));
      end
      check("lit_serve_req_high", 32'(serve_req), 32'd1);
      check("lit_serve_dir_first", 32'(serve_dir), 32'd0);
      cyc(1);
      check("lit_serve_req_one_cycle", 32'(serve_req), 32'd0);

      pulse_miss(1'b0, 1'b1);
      check("lit_p1_point", 32'(score_p1), 32'd1);
      check("lit_point_sq_off", 32'(sq_shown), 32'd0);
      check("lit_point_dir", 32'(serve_dir), 32'd0);
      ticks(3);
      check("lit_pause_to_serve", 32'(sq_shown), 32'd1);
      ticks(3);
      check("lit_no_early_serve", 32'(serve_req), 32'd0);
      ticks(1);
      check("lit_second_serve", 32'(serve_req), 32'd1);

      pulse_miss(1'b1, 1'b1);
      check("lit_both_scores", 32'({score_p1, score_p2}), 32'h10);
      check("lit_both_dir", 32'(serve_dir), 32'd0);
      check("lit_both_pause_sq", 32'(sq_shown), 32'd0);
      ticks(3);
      ticks(4);

      for (int k = 1; k <= 3; k++) begin
         pulse_miss(1'b1, 1'b0);
         check("lit_p2_point", 32'(score_p2), 32'(k));
         check("lit_p2_dir", 32'(serve_dir), 32'd1);
         if (k < 3) begin
            ticks(3);
            ticks(4);
         end
      end
      check("lit_over", 32'(game_over), 32'd1);
      check("lit_over_sq", 32'(sq_shown), 32'd0);
      pulse_miss(1'b1, 1'b0);
      pulse_miss(1'b0, 1'b1);
      check("lit_over_scores_held", 32'({score_p1, score_p2}), 32'h13);
`ifdef PONG_ATTRACT_EN
      ticks(4);
      check("lit_attract_not_yet", 32'(game_over), 32'd1);
      ticks(1);
      check("lit_attract_return", 32'(game_startup), 32'd1);
`else
      ticks(10);
      check("lit_over_persists", 32'(game_over), 32'd1);
      start_btn = 1'b1;
      cyc(3);
      check("lit_over_press_startup", 32'(game_startup), 32'd1);
      check("lit_over_press_not_over", 32'(game_over), 32'd0);
      check("lit_scores_kept", 32'(score_p2), 32'd3);
      start_btn = 1'b0;
`endif

      cyc(3);
      start_btn = 1'b1;
      cyc(3);
      start_btn = 1'b0;
      ticks(4);
      check("lit_serve_before_reset", 32'(serve_req), 32'd1);
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
      check("lit_midplay_reset_startup", 32'(game_startup), 32'd1);
      check("lit_midplay_reset_serve", 32'(serve_req), 32'd0);
      check("lit_midplay_reset_scores", 32'({score_p1, score_p2}), 32'd0);

      repeat (4000) begin
         frame_tick = ($urandom_range(0, 2) == 0);
         miss_left  = ($urandom_range(0, 9) == 0);
         miss_right = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
         rst = ($urandom_range(0, 499) != 0);
         @(negedge clk_0);
      end
      frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0; rst = 1'b1;
      cyc(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pong_match_sequencer.md
Name: pong_match_sequencer

Overview:
Match-level controller that sequences the pong display/game datapath. Drives game_startup, game_over, sq_shown and both 4-bit scores consumed by the renderer, and issues serve requests to ball physics. All timing is counted in frames via a one-cycle frame_tick (start of vblank). Sits between the input/physics logic and the renderer.

Parameters:
WIN_SCORE, 7, score that ends the match (1..15)
SERVE_FRAMES, 60, frames in SERVE_WAIT before the ball is released (1..255)
PAUSE_FRAMES, 90, frames in POINT_PAUSE after a point (1..255)
BLINK_FRAMES, 8, frames per sq_shown toggle during SERVE_WAIT (1..255)
ATTRACT_FRAMES, 240, frames in OVER before auto-return (PONG_ATTRACT_EN only; 1..255)

Ports:
clk_0  in  1  pixel clock, 25.175 MHz
rst  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse per frame, synchronous to clk_0
start_btn  in  1  raw asynchronous start button, high = pressed
miss_left  in  1  one-cycle pulse: ball exited past left paddle
miss_right  in  1  one-cycle pulse: ball exited past right paddle
game_startup  out  1  startup menu active
game_over  out  1  game-over screen active
sq_shown  out  1  ball visible
score_p1  out  4  left player score
score_p2  out  4  right player score
serve_req  out  1  one-cycle pulse: physics re-centres and launches ball
serve_dir  out  1  launch direction, 0 = rightward, 1 = leftward

Behaviour:
- Reset: clk_0, rst synchronous active-low, overrides all. State STARTUP; game_startup=1, game_over=0, sq_shown=0, scores=0, serve_req=0, serve_dir=0, frame counter=0, blink phase=1.
- Button: 2-FF synchronizer plus edge register; all three reset to 1, so a button held through reset gives no press until released and re-pressed. press = sync high & previous low. Raw rising edge to state/output change on the 3rd clk_0 edge.
- All outputs registered; game_startup and game_over never both 1.
- Frame counter (8 bit): cleared on every state change; increments on frame_tick.
- STARTUP: game_startup=1, sq_shown=0. press -> SERVE_WAIT; scores cleared, serve_dir=0.
- SERVE_WAIT: sq_shown=1 on entry, toggles after every BLINK_FRAMES frame_ticks. On the SERVE_FRAMES-th tick: go to PLAY, sq_shown=1, serve_req=1 for exactly one cycle.
- PLAY: sq_shown=1.
  - miss_left -> score_p2+1, serve_dir=1.
  - miss_right -> score_p1+1, serve_dir=0.
  - Both in the same cycle -> no score change, serve_dir unchanged, go to POINT_PAUSE.
  - After a score: if the new score equals WIN_SCORE go to OVER, else POINT_PAUSE. sq_shown=0 in the same update.
  - Misses outside PLAY are ignored.
- POINT_PAUSE: sq_shown=0. On the PAUSE_FRAMES-th tick -> SERVE_WAIT.
- OVER: game_over=1, sq_shown=0, scores held. press -> STARTUP (scores keep displaying until the next game starts).
- Scores saturate at WIN_SCORE and never wrap.
- press is ignored in SERVE_WAIT, PLAY and POINT_PAUSE.
- press and frame_tick in the same cycle: press wins the transition and the counter is cleared.
- A miss and the last serve tick cannot coincide, since misses only count in PLAY.
- Reset mid-PLAY: next cycle is STARTUP with reset values; any serve_req in flight is dropped.

Optional Feature:
PONG_ATTRACT_EN
- Defined: in OVER, on the ATTRACT_FRAMES-th frame_tick, return to STARTUP automatically; press still returns immediately.
- Undefined: OVER is left only by press or reset; the ATTRACT_FRAMES parameter is unused.

Test Plan:
- Test parameters: WIN_SCORE=3, SERVE_FRAMES=4, PAUSE_FRAMES=3, BLINK_FRAMES=2.
- Reset with start_btn held high, release, press again -> game_startup stays 1 until the re-press. game_startup falls on the 3rd edge after the press; scores 0/0.
- From SERVE_WAIT, 4 frame_ticks -> sq_shown pattern 1,1,0,0 then 1. serve_req high exactly 1 cycle after the 4th tick; serve_dir=0.
- In PLAY, pulse miss_right -> score_p1=1, sq_shown=0, serve_dir=0. After 3 ticks SERVE_WAIT; after 4 more ticks serve_req.
- In PLAY, miss_left and miss_right in the same cycle -> scores unchanged, POINT_PAUSE entered, serve_dir unchanged.
- Three miss_left points -> score_p2=3, game_over=1, sq_shown=0. Further miss pulses leave score_p2 at 3. press -> game_startup=1, game_over=0.
- With PONG_ATTRACT_EN and ATTRACT_FRAMES=5: in OVER, 5 frame_ticks -> game_startup=1. Without the macro, after 10 ticks game_over is still 1.
